// File: rtl/commit_unit.sv
// commit_unit: retirement stage behind the reorder buffer.
//   Accepts one retiring entry per cycle and, one cycle later, drives the
//   register-file write, the branch-predictor update and, on a mispredict,
//   a single-cycle clear_branch_out pulse together with the fetch redirect.
//   After a mispredict, the next FLUSH_CYCLES commits are dropped because they
//   are younger, wrong-path entries.
// Ports:
//   clk_in, rst_in (sync, active high), rdy_in (low = freeze everything)
//   commit_en_in, instr_id_in, rd_in, rob_pos_in, res_in,
//   jump_en_in, jump_a_in, pc_in, bp_in           : retiring entry
//   rf_wr_en/rd/data/rob_pos_out                  : register file write
//   bp_upd_en/pc/taken_out                        : predictor training
//   clear_branch_out, redirect_pc_out             : flush pulse + new fetch PC
//   perf_commit_cnt_out, perf_mispred_cnt_out     : performance counters
// Optional feature: define COMMIT_PERF_CNT_EN to build the performance
//   counters. When it is undefined, both counter ports are tied to zero.
module commit_unit #(
  parameter int ROB_IDX_W    = 4,
  parameter int INSTR_ID_W   = 6,
  parameter int REG_IDX_W    = 5,
  parameter int WORD_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int BR_ID_LO     = 5,
  parameter int BR_ID_HI     = 10,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  commit_en_in,
  input  logic [INSTR_ID_W-1:0] instr_id_in,
  input  logic [REG_IDX_W-1:0]  rd_in,
  input  logic [ROB_IDX_W-1:0]  rob_pos_in,
  input  logic [WORD_W-1:0]     res_in,
  input  logic                  jump_en_in,
  input  logic [ADDR_W-1:0]     jump_a_in,
  input  logic [ADDR_W-1:0]     pc_in,
  input  logic                  bp_in,
  output logic                  rf_wr_en_out,
  output logic [REG_IDX_W-1:0]  rf_wr_rd_out,
  output logic [WORD_W-1:0]     rf_wr_data_out,
  output logic [ROB_IDX_W-1:0]  rf_wr_rob_pos_out,
  output logic                  bp_upd_en_out,
  output logic [ADDR_W-1:0]     bp_upd_pc_out,
  output logic                  bp_upd_taken_out,
  output logic                  clear_branch_out,
  output logic [ADDR_W-1:0]     redirect_pc_out,
  output logic [31:0]           perf_commit_cnt_out,
  output logic [31:0]           perf_mispred_cnt_out
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {ST_IDLE, ST_FLUSH} state_t;

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_flush_cnt, w_flush_cnt_nxt;

  logic                  r_rf_en, w_rf_en_nxt;
  logic [REG_IDX_W-1:0]  r_rf_rd, w_rf_rd_nxt;
  logic [WORD_W-1:0]     r_rf_data, w_rf_data_nxt;
  logic [ROB_IDX_W-1:0]  r_rf_pos, w_rf_pos_nxt;
  logic                  r_bp_en, w_bp_en_nxt;
  logic [ADDR_W-1:0]     r_bp_pc, w_bp_pc_nxt;
  logic                  r_bp_taken, w_bp_taken_nxt;
  logic                  r_clear, w_clear_nxt;
  logic [ADDR_W-1:0]     r_redirect, w_redirect_nxt;

  logic                  w_accept;
  logic                  w_mispred;
  logic                  w_is_branch;

  assign w_accept    = commit_en_in && (r_state == ST_IDLE);
  assign w_mispred   = w_accept && (jump_en_in != bp_in);
  assign w_is_branch = (instr_id_in >= INSTR_ID_W'(BR_ID_LO)) &&
                       (instr_id_in <= INSTR_ID_W'(BR_ID_HI));

  always_comb begin
    // Strobes default low; data and address fields keep their last values.
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_rf_en_nxt     = 1'b0;
    w_rf_rd_nxt     = r_rf_rd;
    w_rf_data_nxt   = r_rf_data;
    w_rf_pos_nxt    = r_rf_pos;
    w_bp_en_nxt     = 1'b0;
    w_bp_pc_nxt     = r_bp_pc;
    w_bp_taken_nxt  = r_bp_taken;
    w_clear_nxt     = 1'b0;
    w_redirect_nxt  = r_redirect;
    unique case (r_state)
      ST_IDLE: begin
        if (commit_en_in) begin
          w_rf_en_nxt    = (rd_in != '0);
          w_rf_rd_nxt    = rd_in;
          w_rf_data_nxt  = res_in;
          w_rf_pos_nxt   = rob_pos_in;
          w_bp_en_nxt    = w_is_branch;
          w_bp_pc_nxt    = pc_in;
          w_bp_taken_nxt = jump_en_in;
          if (w_mispred) begin
            w_clear_nxt     = 1'b1;
            w_redirect_nxt  = jump_en_in ? jump_a_in : (pc_in + ADDR_W'(4));
            w_state_nxt     = ST_FLUSH;
            w_flush_cnt_nxt = CNT_W'(FLUSH_CYCLES - 1);
          end
        end
      end
      ST_FLUSH: begin
        // Wrong-path commits are dropped, including one arriving on the exit edge.
        if (r_flush_cnt == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= ST_IDLE;
      r_flush_cnt <= '0;
      r_rf_en     <= 1'b0;
      r_rf_rd     <= '0;
      r_rf_data   <= '0;
      r_rf_pos    <= '0;
      r_bp_en     <= 1'b0;
      r_bp_pc     <= '0;
      r_bp_taken  <= 1'b0;
      r_clear     <= 1'b0;
      r_redirect  <= '0;
    end else if (rdy_in) begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_rf_en     <= w_rf_en_nxt;
      r_rf_rd     <= w_rf_rd_nxt;
      r_rf_data   <= w_rf_data_nxt;
      r_rf_pos    <= w_rf_pos_nxt;
      r_bp_en     <= w_bp_en_nxt;
      r_bp_pc     <= w_bp_pc_nxt;
      r_bp_taken  <= w_bp_taken_nxt;
      r_clear     <= w_clear_nxt;
      r_redirect  <= w_redirect_nxt;
    end
  end

  assign rf_wr_en_out      = r_rf_en;
  assign rf_wr_rd_out      = r_rf_rd;
  assign rf_wr_data_out    = r_rf_data;
  assign rf_wr_rob_pos_out = r_rf_pos;
  assign bp_upd_en_out     = r_bp_en;
  assign bp_upd_pc_out     = r_bp_pc;
  assign bp_upd_taken_out  = r_bp_taken;
  assign clear_branch_out  = r_clear;
  assign redirect_pc_out   = r_redirect;

`ifdef COMMIT_PERF_CNT_EN
  logic [31:0] r_perf_commit;
  logic [31:0] r_perf_mispred;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_perf_commit  <= '0;
      r_perf_mispred <= '0;
    end else if (rdy_in) begin
      if (w_accept)  r_perf_commit  <= r_perf_commit + 32'd1;
      if (w_mispred) r_perf_mispred <= r_perf_mispred + 32'd1;
    end
  end

  assign perf_commit_cnt_out  = r_perf_commit;
  assign perf_mispred_cnt_out = r_perf_mispred;
`else
  assign perf_commit_cnt_out  = '0;
  assign perf_mispred_cnt_out = '0;
`endif

endmodule

// File: tb/tb_commit_unit.sv
module tb_commit_unit;
  localparam int FLUSH = 2;
  localparam int LO    = 5;
  localparam int HI    = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0, rdy = 1'b1, cen = 1'b0, jmp = 1'b0, bp = 1'b0;
  logic [5:0]  id = '0;
  logic [4:0]  rd = '0;
  logic [3:0]  pos = '0;
  logic [31:0] res = '0, ja = '0, pc = '0;

  logic        o_rf_en, o_bp_en, o_taken, o_clear;
  logic [4:0]  o_rd;
  logic [31:0] o_data, o_bp_pc, o_redir, o_pcnt, o_mcnt;
  logic [3:0]  o_pos;

  always #5 clk = ~clk;

  commit_unit #(
    .ROB_IDX_W(4), .INSTR_ID_W(6), .REG_IDX_W(5), .WORD_W(32), .ADDR_W(32),
    .BR_ID_LO(LO), .BR_ID_HI(HI), .FLUSH_CYCLES(FLUSH)
  ) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .commit_en_in(cen),
    .instr_id_in(id), .rd_in(rd), .rob_pos_in(pos), .res_in(res),
    .jump_en_in(jmp), .jump_a_in(ja), .pc_in(pc), .bp_in(bp),
    .rf_wr_en_out(o_rf_en), .rf_wr_rd_out(o_rd), .rf_wr_data_out(o_data),
    .rf_wr_rob_pos_out(o_pos), .bp_upd_en_out(o_bp_en), .bp_upd_pc_out(o_bp_pc),
    .bp_upd_taken_out(o_taken), .clear_branch_out(o_clear),
    .redirect_pc_out(o_redir), .perf_commit_cnt_out(o_pcnt),
    .perf_mispred_cnt_out(o_mcnt)
  );

  // Reference model: number of commits still to be dropped plus expected outputs.
  typedef struct {
    bit        rf_en; bit [4:0] rd; bit [31:0] data; bit [3:0] pos;
    bit        bp_en; bit [31:0] bp_pc; bit taken;
    bit        clear; bit [31:0] redir; bit [31:0] pcnt; bit [31:0] mcnt;
  } out_t;
  out_t m;
  int   drops_left;
  int   n_vec = 0, n_err = 0;

  task automatic model_step();
    if (rst) begin
      m = '{default: 0};
      drops_left = 0;
    end else if (rdy) begin
      m.rf_en = 0; m.bp_en = 0; m.clear = 0;
      if (drops_left > 0) begin
        drops_left--;
      end else if (cen) begin
        m.rf_en = (rd != 0); m.rd = rd; m.data = res; m.pos = pos;
        m.bp_en = (int'(id) >= LO) && (int'(id) <= HI);
        m.bp_pc = pc; m.taken = jmp;
        m.pcnt++;
        if (jmp != bp) begin
          m.clear = 1;
          m.redir = jmp ? ja : pc + 32'd4;
          drops_left = FLUSH;
          m.mcnt++;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " rf_en"}, 64'(o_rf_en), 64'(m.rf_en));
    if (m.rf_en) begin
      chk({tag, " rf_rd"}, 64'(o_rd), 64'(m.rd));
      chk({tag, " rf_data"}, 64'(o_data), 64'(m.data));
      chk({tag, " rf_pos"}, 64'(o_pos), 64'(m.pos));
    end
    chk({tag, " bp_en"}, 64'(o_bp_en), 64'(m.bp_en));
    if (m.bp_en) begin
      chk({tag, " bp_pc"}, 64'(o_bp_pc), 64'(m.bp_pc));
      chk({tag, " bp_taken"}, 64'(o_taken), 64'(m.taken));
    end
    chk({tag, " clear"}, 64'(o_clear), 64'(m.clear));
    chk({tag, " redirect"}, 64'(o_redir), 64'(m.redir));
`ifdef COMMIT_PERF_CNT_EN
    chk({tag, " perf_commit"}, 64'(o_pcnt), 64'(m.pcnt));
    chk({tag, " perf_mispred"}, 64'(o_mcnt), 64'(m.mcnt));
`else
    chk({tag, " perf_commit"}, 64'(o_pcnt), 64'd0);
    chk({tag, " perf_mispred"}, 64'(o_mcnt), 64'd0);
`endif
  endtask

  task automatic do_reset();
    rst = 1; cen = 0; rdy = 1;
    tick();
    rst = 0;
  endtask

  task automatic set_commit(input bit [5:0] i_id, input bit [4:0] i_rd, input bit [3:0] i_pos,
                            input bit [31:0] i_res, input bit i_jmp, input bit [31:0] i_ja,
                            input bit [31:0] i_pc, input bit i_bp);
    cen = 1; id = i_id; rd = i_rd; pos = i_pos; res = i_res;
    jmp = i_jmp; ja = i_ja; pc = i_pc; bp = i_bp;
  endtask

  typedef struct {
    string nm;
    bit [5:0] id; bit [4:0] rd; bit [3:0] pos; bit [31:0] res;
    bit jmp; bit [31:0] ja; bit [31:0] pc; bit bp;
    bit e_rf; bit [4:0] e_rd; bit [31:0] e_data; bit [3:0] e_pos;
    bit e_bp; bit e_taken; bit e_clear; bit [31:0] e_redir;
  } vec_t;
  vec_t tbl[8];

  initial begin
    m = '{default: 0};
    drops_left = 0;

    // Each vector is a single commit applied straight after reset.
    tbl[0] = '{"rf_write",   6'd0,  5'd5, 4'd3, 32'hDEADBEEF, 1'b0, 32'h0,    32'h40,       1'b0,
               1'b1, 5'd5, 32'hDEADBEEF, 4'd3, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{"rd_zero",    6'd1,  5'd0, 4'd2, 32'h1234,     1'b0, 32'h0,    32'h44,       1'b0,
               1'b0, 5'd0, 32'h0,        4'd0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[2] = '{"br_mispred", 6'd7,  5'd0, 4'd1, 32'h0,        1'b0, 32'h0,    32'h100,      1'b1,
               1'b0, 5'd0, 32'h0,        4'd0, 1'b1, 1'b0, 1'b1, 32'h104};
    tbl[3] = '{"jalr",       6'd20, 5'd1, 4'd6, 32'h108,      1'b1, 32'h2000, 32'h104,      1'b0,
               1'b1, 5'd1, 32'h108,      4'd6, 1'b0, 1'b0, 1'b1, 32'h2000};
    tbl[4] = '{"br_id_hi",   6'd10, 5'd3, 4'd7, 32'h55,       1'b1, 32'h300,  32'h200,      1'b1,
               1'b1, 5'd3, 32'h55,       4'd7, 1'b1, 1'b1, 1'b0, 32'h0};
    tbl[5] = '{"br_id_lo",   6'd5,  5'd0, 4'd8, 32'h0,        1'b0, 32'h0,    32'h210,      1'b0,
               1'b0, 5'd0, 32'h0,        4'd0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[6] = '{"id_above",   6'd11, 5'd2, 4'd9, 32'h77,       1'b0, 32'h0,    32'h220,      1'b0,
               1'b1, 5'd2, 32'h77,       4'd9, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[7] = '{"pc_wrap",    6'd4,  5'd0, 4'd4, 32'h0,        1'b0, 32'h0,    32'hFFFFFFFC, 1'b1,
               1'b0, 5'd0, 32'h0,        4'd0, 1'b0, 1'b0, 1'b1, 32'h0};

    // Reset state: every output is zero.
    do_reset();
    chk("rst rf_en", 64'(o_rf_en), 0);   chk("rst rf_rd", 64'(o_rd), 0);
    chk("rst rf_data", 64'(o_data), 0);  chk("rst rf_pos", 64'(o_pos), 0);
    chk("rst bp_en", 64'(o_bp_en), 0);   chk("rst bp_pc", 64'(o_bp_pc), 0);
    chk("rst taken", 64'(o_taken), 0);   chk("rst clear", 64'(o_clear), 0);
    chk("rst redirect", 64'(o_redir), 0);
    chk("rst perf_c", 64'(o_pcnt), 0);   chk("rst perf_m", 64'(o_mcnt), 0);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      set_commit(tbl[i].id, tbl[i].rd, tbl[i].pos, tbl[i].res, tbl[i].jmp, tbl[i].ja, tbl[i].pc, tbl[i].bp);
      tick();
      cen = 0;
      chk({tbl[i].nm, " rf_en"}, 64'(o_rf_en), 64'(tbl[i].e_rf));
      if (tbl[i].e_rf) begin
        chk({tbl[i].nm, " rf_rd"}, 64'(o_rd), 64'(tbl[i].e_rd));
        chk({tbl[i].nm, " rf_data"}, 64'(o_data), 64'(tbl[i].e_data));
        chk({tbl[i].nm, " rf_pos"}, 64'(o_pos), 64'(tbl[i].e_pos));
      end
      chk({tbl[i].nm, " bp_en"}, 64'(o_bp_en), 64'(tbl[i].e_bp));
      if (tbl[i].e_bp) chk({tbl[i].nm, " taken"}, 64'(o_taken), 64'(tbl[i].e_taken));
      chk({tbl[i].nm, " clear"}, 64'(o_clear), 64'(tbl[i].e_clear));
      chk({tbl[i].nm, " redirect"}, 64'(o_redir), 64'(tbl[i].e_redir));
      tick();
      chk({tbl[i].nm, " clear_1cyc"}, 64'(o_clear), 0);
    end

    // Commits on the two cycles after a mispredict are dropped, the third is taken.
    do_reset();
    set_commit(6'd7, 5'd0, 4'd1, 32'h0, 1'b0, 32'h0, 32'h100, 1'b1);
    tick();
    chk("flush clear", 64'(o_clear), 1);
    chk("flush redirect", 64'(o_redir), 64'h104);
    for (int k = 0; k < FLUSH; k++) begin
      set_commit(6'd1, 5'd7, 4'd2, 32'hAA, 1'b1, 32'h500, 32'h108, 1'b0);
      tick();
      chk("flush drop rf_en", 64'(o_rf_en), 0);
      chk("flush drop clear", 64'(o_clear), 0);
      chk("flush drop bp_en", 64'(o_bp_en), 0);
    end
    set_commit(6'd1, 5'd9, 4'd5, 32'hBB, 1'b0, 32'h0, 32'h10C, 1'b0);
    tick();
    cen = 0;
    chk("after flush rf_en", 64'(o_rf_en), 1);
    chk("after flush rf_rd", 64'(o_rd), 9);
    chk("after flush data", 64'(o_data), 64'hBB);
    chk("after flush redirect held", 64'(o_redir), 64'h104);

    // rdy low mid-flush freezes everything; reset mid-flush returns to idle.
    do_reset();
    set_commit(6'd8, 5'd4, 4'd3, 32'h44, 1'b1, 32'h900, 32'h800, 1'b0);
    tick();
    set_commit(6'd1, 5'd6, 4'd1, 32'h66, 1'b0, 32'h0, 32'h804, 1'b0);
    rdy = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall clear held", 64'(o_clear), 1);
      chk("stall rf_en held", 64'(o_rf_en), 1);
      chk("stall rf_data held", 64'(o_data), 64'h44);
      chk("stall redirect held", 64'(o_redir), 64'h900);
    end
    rdy = 1;
    tick();
    chk("post stall drop rf_en", 64'(o_rf_en), 0);
    chk("post stall clear", 64'(o_clear), 0);
    rst = 1;
    tick();
    rst = 0;
    chk("rst flush rf_en", 64'(o_rf_en), 0);
    chk("rst flush clear", 64'(o_clear), 0);
    chk("rst flush redirect", 64'(o_redir), 0);
    chk("rst flush data", 64'(o_data), 0);
    tick();
    cen = 0;
    chk("rst flush idle accept", 64'(o_rf_en), 1);
    chk("rst flush idle rd", 64'(o_rd), 6);

    // Randomized traffic against the reference model.
    do_reset();
    check_model("rand start");
    for (int n = 0; n < 2000; n++) begin
      rst = ($urandom_range(99) == 0);
      rdy = ($urandom_range(9) != 0);
      cen = ($urandom_range(9) < 7);
      id  = 6'($urandom_range(15));
      rd  = 5'($urandom_range(7));
      pos = 4'($urandom);
      res = $urandom;
      jmp = 1'($urandom);
      bp  = ($urandom_range(3) == 0) ? ~jmp : jmp;
      ja  = $urandom;
      pc  = ($urandom_range(15) == 0) ? 32'hFFFFFFFC : {$urandom_range(32'h3FFF_FFFF), 2'b00};
      tick();
      check_model("rand");
    end
    rst = 0; rdy = 1; cen = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
